// File: rtl/staged_incr_chain_pkg.sv
`default_nettype none
// ============================================================================
// Module   : staged_incr_chain_pkg
// Purpose  : Shared types, defaults and the per-stage increment function for
//            the staged increment pipeline.
// Revision : 1.0 - initial release
// ============================================================================
package staged_incr_chain_pkg;

  localparam int WIDTH_DEF = 8;
  localparam int STEP_DEF  = 1;
  localparam int CNT_W_DEF = 16;

  // Widest word the increment helper can evaluate; one spare bit on top
  // catches the carry used by the saturating mode.
  localparam int MAX_W = 64;

  // Stage record {valid, data} at the default width.
  typedef struct packed {
    logic                 valid;
    logic [WIDTH_DEF-1:0] data;
  } stage_t;

  // One increment step on a width-bit word. Callers zero-extend x/step to
  // MAX_W and truncate the result back to their own width.
  function automatic logic [MAX_W:0] incr_step(
    input logic [MAX_W-1:0] x,
    input logic [MAX_W-1:0] step,
    input int               width,
    input logic             sat
  );
    logic [MAX_W:0] sum;
    logic [MAX_W:0] lim;
    sum = {1'b0, x} + {1'b0, step};
    lim = ((MAX_W+1)'(1) << width) - (MAX_W+1)'(1);
    if (sat) begin
      return (sum > lim) ? lim : sum;
    end
    return sum & lim;
  endfunction

endpackage : staged_incr_chain_pkg
`default_nettype wire

// File: rtl/staged_incr_chain_stage.sv
`default_nettype none
// ============================================================================
// Module   : incr_stage
// Purpose  : One registered increment stage with valid/advance handshake.
//            The stage loads when it is empty or when the stage ahead moves.
// Revision : 1.0 - initial release
// ============================================================================
module incr_stage
  import staged_incr_chain_pkg::*;
#(
  parameter int WIDTH    = WIDTH_DEF,
  parameter int STEP     = STEP_DEF,
  parameter int SATURATE = 0
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             i_up_valid,
  input  logic [WIDTH-1:0] i_up_data,
  input  logic             i_adv_next,
  output logic             o_adv,
  output logic             o_valid,
  output logic [WIDTH-1:0] o_data
);

  logic             r_valid;
  logic [WIDTH-1:0] r_data;
  logic [WIDTH-1:0] w_next_data;

  assign o_adv       = !r_valid || i_adv_next;
  assign w_next_data = WIDTH'(incr_step(MAX_W'(i_up_data), MAX_W'(STEP),
                                        WIDTH, (SATURATE != 0)));
  assign o_valid     = r_valid;
  assign o_data      = r_data;

  // Capture the upstream word when advancing; data holds across bubbles.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_valid <= 1'b0;
      r_data  <= '0;
    end else if (o_adv) begin
      r_valid <= i_up_valid;
      if (i_up_valid) begin
        r_data <= w_next_data;
      end
    end
  end

endmodule : incr_stage
`default_nettype wire

// File: rtl/staged_incr_chain.sv
`default_nettype none
// ============================================================================
// Module   : staged_incr_chain
// Purpose  : STAGES-deep pipeline of registered increment stages with
//            valid/ready at both ends, occupancy flag and completion counter.
// Revision : 1.0 - initial release
// ============================================================================
module staged_incr_chain
  import staged_incr_chain_pkg::*;
#(
  parameter int WIDTH    = WIDTH_DEF,
  parameter int STAGES   = 2,
  parameter int STEP     = STEP_DEF,
  parameter int SATURATE = 0,
  parameter int CNT_W    = CNT_W_DEF
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             busy,
  output logic [CNT_W-1:0] done_count
);

  // Index 0 is the producer side; index i+1 is the output of stage i.
  logic [STAGES:0]            w_valid;
  logic [STAGES:0][WIDTH-1:0] w_data;
  // w_adv[i] is the advance of stage i; w_adv[STAGES] is the consumer.
  logic [STAGES:0]            w_adv;
  logic                       w_xfer;
  logic [CNT_W-1:0]           r_done_count;

  assign w_valid[0]     = in_valid;
  assign w_data[0]      = in_data;
  assign w_adv[STAGES]  = out_ready;

  for (genvar gi = 0; gi < STAGES; gi++) begin : g_stage
    incr_stage #(
      .WIDTH    (WIDTH),
      .STEP     (STEP),
      .SATURATE (SATURATE)
    ) u_stage (
      .clock      (clock),
      .reset      (reset),
      .i_up_valid (w_valid[gi]),
      .i_up_data  (w_data[gi]),
      .i_adv_next (w_adv[gi+1]),
      .o_adv      (w_adv[gi]),
      .o_valid    (w_valid[gi+1]),
      .o_data     (w_data[gi+1])
    );
  end

  // Stage 0 registers ignore the advance while in reset, so the producer
  // must not see a ready that would silently drop its word.
  assign in_ready   = w_adv[0] && !reset;
  assign out_valid  = w_valid[STAGES];
  assign out_data   = w_data[STAGES];
  assign busy       = |w_valid[STAGES:1];
  assign w_xfer     = out_valid && out_ready;
  assign done_count = r_done_count;

  // Count completed output transfers, wrapping naturally at 2**CNT_W.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_done_count <= '0;
    end else if (w_xfer) begin
      r_done_count <= r_done_count + CNT_W'(1);
    end
  end

endmodule : staged_incr_chain
`default_nettype wire

// File: tb/tb_staged_incr_chain.sv
`timescale 1ns/1ps
module tb_staged_incr_chain;

  // Three configurations: default wrap, default saturating, wide/deep.
  localparam int W0 = 8,  S0 = 2, P0 = 1, T0 = 0;
  localparam int W1 = 8,  S1 = 2, P1 = 1, T1 = 1;
  localparam int W2 = 12, S2 = 4, P2 = 3, T2 = 0;

  int W_  [3] = '{W0, W1, W2};
  int S_  [3] = '{S0, S1, S2};
  int STP [3] = '{P0, P1, P2};
  int SAT [3] = '{T0, T1, T2};

  logic        clk = 1'b0;
  logic [2:0]  rst  = 3'b111;
  logic [2:0]  iv   = 3'b000;
  logic [2:0]  ordy = 3'b000;
  logic [15:0] id [3];
  logic [2:0]  ir, ov, bz;
  logic [15:0] od [3];
  logic [15:0] dc [3];
  logic [7:0]  od0, od1;
  logic [11:0] od2;

  int checks   = 0;
  int failures = 0;
  bit chk_en   = 1'b0;
  int cyc      = 0;

  // Reference model: per-DUT FIFO of expected results and acceptance times.
  logic [15:0] qd [3][$];
  int          qt [3][$];
  logic [15:0] mdone [3];

  always #5 clk = ~clk;

  initial begin
    for (int k = 0; k < 3; k++) begin
      id[k]    = '0;
      mdone[k] = '0;
    end
  end

  staged_incr_chain #(.WIDTH(W0), .STAGES(S0), .STEP(P0), .SATURATE(T0), .CNT_W(16)) u_dut0 (
    .clock(clk), .reset(rst[0]), .in_valid(iv[0]), .in_ready(ir[0]), .in_data(id[0][7:0]),
    .out_valid(ov[0]), .out_ready(ordy[0]), .out_data(od0), .busy(bz[0]), .done_count(dc[0]));
  staged_incr_chain #(.WIDTH(W1), .STAGES(S1), .STEP(P1), .SATURATE(T1), .CNT_W(16)) u_dut1 (
    .clock(clk), .reset(rst[1]), .in_valid(iv[1]), .in_ready(ir[1]), .in_data(id[1][7:0]),
    .out_valid(ov[1]), .out_ready(ordy[1]), .out_data(od1), .busy(bz[1]), .done_count(dc[1]));
  staged_incr_chain #(.WIDTH(W2), .STAGES(S2), .STEP(P2), .SATURATE(T2), .CNT_W(16)) u_dut2 (
    .clock(clk), .reset(rst[2]), .in_valid(iv[2]), .in_ready(ir[2]), .in_data(id[2][11:0]),
    .out_valid(ov[2]), .out_ready(ordy[2]), .out_data(od2), .busy(bz[2]), .done_count(dc[2]));

  assign od[0] = 16'(od0);
  assign od[1] = 16'(od1);
  assign od[2] = 16'(od2);

  // STAGES applications of the single-step rule, in plain integers.
  function automatic logic [15:0] model_f(int k, logic [15:0] x);
    int v;
    int mx;
    v  = int'(x);
    mx = (1 << W_[k]) - 1;
    for (int s = 0; s < S_[k]; s++) begin
      v = v + STP[k];
      if (SAT[k] != 0) v = (v > mx) ? mx : v;
      else             v = v & mx;
    end
    return 16'(v);
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // The oldest word never waits on anything ahead of it, so it reaches the
  // output exactly STAGES-1 edges after the edge that accepted it.
  function automatic bit model_ov(int k);
    return (qd[k].size() > 0) && (cyc >= qt[k][0] + S_[k] - 1);
  endfunction

  // Model update on each edge from the pre-edge inputs.
  always @(posedge clk) begin
    for (int k = 0; k < 3; k++) begin
      if (rst[k]) begin
        qd[k].delete();
        qt[k].delete();
        mdone[k] = '0;
      end else begin
        bit eov;
        bit eir;
        eov = model_ov(k);
        eir = (qd[k].size() < S_[k]) || ordy[k];
        if (eov && ordy[k]) begin
          void'(qd[k].pop_front());
          void'(qt[k].pop_front());
          mdone[k] = mdone[k] + 16'd1;
        end
        if (iv[k] && eir) begin
          qd[k].push_back(model_f(k, id[k]));
          qt[k].push_back(cyc + 1);
        end
      end
    end
    cyc = cyc + 1;
  end

  // Compare every DUT against the model each cycle, mid-period.
  always @(negedge clk) begin
    if (chk_en) begin
      for (int k = 0; k < 3; k++) begin
        bit eov;
        eov = model_ov(k);
        chk($sformatf("out_valid[%0d]", k), 32'(ov[k]), 32'(eov));
        if (eov) chk($sformatf("out_data[%0d]", k), 32'(od[k]), 32'(qd[k][0]));
        chk($sformatf("in_ready[%0d]", k), 32'(ir[k]),
            32'(!rst[k] && ((qd[k].size() < S_[k]) || ordy[k])));
        chk($sformatf("busy[%0d]", k), 32'(bz[k]), 32'(qd[k].size() > 0));
        chk($sformatf("done_count[%0d]", k), 32'(dc[k]), 32'(mdone[k]));
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic rst_dut(input int k);
    rst[k] = 1'b1;
    step();
    rst[k] = 1'b0;
  endtask

  // Push one word through an otherwise idle pipe and pin its result.
  task automatic lit_pass(input int k, input logic [15:0] din, input logic [15:0] exp, input string nm);
    ordy[k] = 1'b1;
    iv[k]   = 1'b1;
    id[k]   = din;
    step();
    iv[k]   = 1'b0;
    repeat (S_[k] - 1) step();
    @(negedge clk);
    chk({nm, "_valid"}, 32'(ov[k]), 32'd1);
    chk(nm, 32'(od[k]), 32'(exp));
    step();
  endtask

  initial begin
    step();
    step();
    @(negedge clk);
    chk("reset_in_ready", 32'(ir[0]), 32'd0);
    rst = 3'b000;
    #1;
    chk("reset_out_valid", 32'(ov[0]), 32'd0);
    chk("reset_out_data",  32'(od[0]), 32'd0);
    chk("reset_busy",      32'(bz[0]), 32'd0);
    chk("reset_done",      32'(dc[0]), 32'd0);
    chk("post_reset_in_ready", 32'(ir[0]), 32'd1);
    chk_en = 1'b1;
    step();

    // Basic and wrap/saturate boundaries.
    lit_pass(0, 16'h05, 16'h07, "basic");
    @(negedge clk);
    chk("basic_done", 32'(dc[0]), 32'd1);
    lit_pass(0, 16'hFF,  16'h01,  "wrap_mod");
    lit_pass(1, 16'hFF,  16'hFF,  "wrap_sat_ff");
    lit_pass(1, 16'hFE,  16'hFF,  "wrap_sat_fe");
    lit_pass(2, 16'hFFE, 16'h00A, "param_w12");

    // Streaming at full rate.
    rst_dut(0);
    ordy[0] = 1'b1;
    for (int i = 0; i < 16; i++) begin
      iv[0] = 1'b1;
      id[0] = 16'(16'h10 + i);
      @(negedge clk);
      chk("stream_in_ready", 32'(ir[0]), 32'd1);
      if (i >= 2) chk("stream_out", 32'(od[0]), 32'(16'h10 + i));
      step();
    end
    iv[0] = 1'b0;
    repeat (4) step();
    @(negedge clk);
    chk("stream_done", 32'(dc[0]), 32'd16);

    // Backpressure.
    rst_dut(0);
    ordy[0] = 1'b0;
    iv[0] = 1'b1; id[0] = 16'h20; step();
    id[0] = 16'h21; step();
    id[0] = 16'h22;
    @(negedge clk);
    chk("bp_in_ready", 32'(ir[0]), 32'd0);
    chk("bp_out_data", 32'(od[0]), 32'h22);
    for (int i = 0; i < 3; i++) begin
      step();
      @(negedge clk);
      chk("bp_hold_data", 32'(od[0]), 32'h22);
      chk("bp_hold_ready", 32'(ir[0]), 32'd0);
    end
    ordy[0] = 1'b1;
    #1;
    chk("bp_release_ready", 32'(ir[0]), 32'd1);
    step();
    iv[0] = 1'b0;
    @(negedge clk);
    chk("bp_out2", 32'(od[0]), 32'h23);
    step();
    @(negedge clk);
    chk("bp_out3", 32'(od[0]), 32'h24);
    step();
    step();

    // Reset with words in flight.
    ordy[0] = 1'b0;
    iv[0] = 1'b1; id[0] = 16'h40; step();
    id[0] = 16'h41; step();
    iv[0] = 1'b0;
    rst[0] = 1'b1;
    step();
    rst[0] = 1'b0;
    @(negedge clk);
    chk("midrst_out_valid", 32'(ov[0]), 32'd0);
    chk("midrst_busy",      32'(bz[0]), 32'd0);
    chk("midrst_done",      32'(dc[0]), 32'd0);
    chk("midrst_out_data",  32'(od[0]), 32'd0);
    ordy[0] = 1'b1;
    repeat (5) step();

    // Completion counter wrap on the deep configuration.
    rst_dut(2);
    ordy[2] = 1'b1;
    iv[2]   = 1'b1;
    for (int n = 0; n < 65535; n++) begin
      id[2] = 16'(n & 'hFFF);
      step();
    end
    iv[2] = 1'b0;
    repeat (6) step();
    @(negedge clk);
    chk("done_ffff", 32'(dc[2]), 32'hFFFF);
    lit_pass(2, 16'h100, 16'h10C, "wrap_xfer");
    @(negedge clk);
    chk("done_wrap0", 32'(dc[2]), 32'd0);

    // Randomised traffic with occasional resets on all configurations.
    for (int c = 0; c < 1500; c++) begin
      for (int k = 0; k < 3; k++) begin
        iv[k]   = 1'($urandom_range(0, 1));
        id[k]   = 16'($urandom) & 16'((1 << W_[k]) - 1);
        ordy[k] = ($urandom_range(0, 9) < 7);
        rst[k]  = ($urandom_range(0, 63) == 0);
      end
      step();
    end
    rst  = 3'b000;
    iv   = 3'b000;
    ordy = 3'b111;
    repeat (10) step();
    @(negedge clk);
    for (int k = 0; k < 3; k++) chk($sformatf("drained_busy[%0d]", k), 32'(bz[k]), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/staged_incr_chain.md
Name: staged_incr_chain

Overview:
- Parametrised pipeline of STAGES registered increment stages, each adding STEP to a WIDTH-bit word.
- Valid/ready handshake at both ends; full throughput with backpressure.
- Successor to the fixed two-call combinational add chain: depth, width, increment and overflow mode are configurable.
- Adds pipelining, stall handling and a completion counter.
- Sits between a producer (e.g. a counter register owner) and a consumer that writes results back.

Parameters:
- WIDTH, 8, data width in bits (>=2).
- STAGES, 2, number of registered increment stages (>=1).
- STEP, 1, unsigned increment applied per stage (0 <= STEP < 2**WIDTH).
- SATURATE, 0, 0 = modular wrap per stage; 1 = clamp each stage result at 2**WIDTH-1.
- CNT_W, 16, width of the completion counter.

Ports:
- clock  in  1  single system clock; all state updates on rising edge.
- reset  in  1  synchronous, active-high reset.
- in_valid  in  1  producer offers in_data.
- in_ready  out  1  stage 0 can accept this cycle.
- in_data  in  WIDTH  operand.
- out_valid  out  1  last stage holds a result.
- out_ready  in  1  consumer accepts result.
- out_data  out  WIDTH  result (in_data after STAGES increments).
- busy  out  1  OR of all stage valid bits.
- done_count  out  CNT_W  number of completed output transfers.

Behaviour:
- Reset:
  - All stage valid bits clear, stage data registers 0, done_count 0.
  - out_valid=0, out_data=0, busy=0.
  - in_ready forced 0 while reset is high.
- Reset mid-operation: all in-flight words are discarded, with no output transfer for them. First accept is possible the cycle after reset deasserts.
- Handshake:
  - A transfer occurs on a cycle where valid&&ready, sampled at the clock edge.
  - out_data/out_valid are stable while out_valid=1 and out_ready=0.
- Stage i (0..STAGES-1) holds v[i], d[i].
  - adv[i] = !v[i] || adv_next, where adv_next for the last stage is out_ready and otherwise adv[i+1].
  - in_ready = adv[0], combinational from out_ready through the chain; no other combinational input-to-output path.
  - When adv[i]: v[i] <= upstream valid, and d[i] <= f(upstream data) if upstream valid, else d[i] holds.
  - Upstream of stage 0 is in_valid/in_data.
- Arithmetic:
  - SATURATE=0: f(x) = (x + STEP) mod 2**WIDTH.
  - SATURATE=1: f(x) = min(x + STEP, 2**WIDTH-1), computed in WIDTH+1 bits.
  - Saturation applies per stage, so the final result equals the single-step formula applied STAGES times.
- Latency: a word accepted at cycle t is presented with out_valid=1 at cycle t+STAGES if there is no stall.
- Throughput: one word per cycle with out_ready held high; a bubble never blocks a valid word behind it.
- Ordering: strictly FIFO; no reordering, duplication or drop.
- Full pipe with out_ready=0: in_ready=0, and all stages hold.
- Simultaneous accept at the input and transfer at the output on a full pipe: legal. Data shifts by one stage and occupancy is unchanged.
- done_count increments by 1 on each out_valid&&out_ready cycle and wraps from 2**CNT_W-1 to 0.
- busy = |v; combinational from registers.

Decomposition:
- Package staged_incr_chain_pkg:
  - typedef for the stage record {valid, data}.
  - Function incr_step(x, step, sat) implementing f.
  - Constant defaults for WIDTH, STEP and CNT_W.
- Sub-module incr_stage (WIDTH, STEP, SATURATE):
  - One valid/data register pair with adv logic and f.
  - Instantiated STAGES times in a generate loop.
- Top level: the generate chain, the done_count register and busy.

Test Plan (WIDTH=8, STAGES=2, STEP=1 unless noted):
- Basic: in_data=0x05 for one cycle, out_ready=1 -> out_valid at +2 cycles with out_data=0x07, then done_count=1.
- Wrap: in_data=0xFF, SATURATE=0 -> out_data=0x01. Same input with SATURATE=1 -> out_data=0xFF. SATURATE=1, in_data=0xFE -> 0xFF.
- Streaming: in_data 0x10..0x1F on consecutive cycles, out_ready=1 -> results 0x12..0x21 on consecutive cycles, in_ready held 1, done_count=16.
- Backpressure: fill with 0x20, 0x21, 0x22 while out_ready=0:
  - in_ready drops after two accepts, and 0x22 is held by the producer.
  - out_data stays 0x22 while stalled.
  - Release out_ready -> outputs 0x22, 0x23, 0x24 in order, with no loss.
- Reset mid-flight: two words in the pipe, assert reset one cycle -> out_valid=0, busy=0, done_count=0 next cycle, and no stale output afterward.
- Parametric: STAGES=4, STEP=3, WIDTH=12, in_data=0xFFE -> out_data=0x00A after 4 cycles; done_count wraps from 0xFFFF to 0 on the next transfer when preloaded by 65535 transfers.
